// File: rtl/fb_rect_writer_pkg.sv
// Shared frame-buffer definitions: geometry, pixel/address widths, writer
// state encoding and the window descriptor used by writer and readers.
package fb_pkg;

  localparam int VBUF_W    = 320;
  localparam int VBUF_H    = 240;
  localparam int FB_PIX_W  = 3;
  localparam int FB_ADDR_W = 17;

  typedef enum logic [1:0] {
    FBW_IDLE   = 2'd0,
    FBW_ACTIVE = 2'd1,
    FBW_DONE   = 2'd2
  } fbw_state_t;

  // Window request as presented on start.
  typedef struct packed {
    logic [8:0] x0;
    logic [7:0] y0;
    logic [8:0] w;
    logic [7:0] h;
  } fbw_win_t;

  // Window is legal when non-empty and fully inside the frame.
  // 10-bit sums so x0+w / y0+h cannot overflow before the compare.
  function automatic logic fbw_win_ok(input fbw_win_t win, input int vw, input int vh);
    logic [9:0] x_end;
    logic [9:0] y_end;
    x_end = {1'b0, win.x0} + {1'b0, win.w};
    y_end = {2'b0, win.y0} + {2'b0, win.h};
    return (win.w != 9'd0) && (win.h != 8'd0) &&
           (x_end <= 10'(vw)) && (y_end <= 10'(vh));
  endfunction

endpackage

// File: rtl/fb_rect_writer_if.sv
// Pixel stream handshake plus the single-port SRAM write bus.
// master = the writer, slave = stream source / SRAM side.
interface fb_rect_writer_if #(
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 17
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  sram_en;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_data;

  modport master (
    input  s_valid, s_data,
    output s_ready, sram_en, sram_we, sram_addr, sram_data
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, sram_en, sram_we, sram_addr, sram_data
  );
endinterface

// File: rtl/fb_rect_writer_addr_gen.sv
// Window address stepper: column/row counters and row_base/addr walk.
// The only multiply (y0*VBUF_W) is by a constant and happens once on load.
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int VBUF_W     = fb_pkg::VBUF_W,
  parameter int ADDR_WIDTH = fb_pkg::FB_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  step,
  input  fbw_win_t              win,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(VBUF_W);

  logic [8:0]            w_q;
  logic [7:0]            h_q;
  logic [8:0]            col;
  logic [7:0]            row;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] start_base;
  logic                  col_end;

  assign start_base = ADDR_WIDTH'(win.y0) * ROW_STEP + ADDR_WIDTH'(win.x0);
  assign col_end    = (col == w_q - 9'd1);
  assign last       = col_end && (row == h_q - 8'd1);

  // Load the window origin on accept, then advance one pixel per write,
  // jumping to the next row_base at the end of each row.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w_q      <= '0;
      h_q      <= '0;
      col      <= '0;
      row      <= '0;
      row_base <= '0;
      addr     <= '0;
    end else if (load) begin
      w_q      <= win.w;
      h_q      <= win.h;
      col      <= '0;
      row      <= '0;
      row_base <= start_base;
      addr     <= start_base;
    end else if (step) begin
      if (col_end) begin
        col      <= '0;
        row      <= row + 8'd1;
        row_base <= row_base + ROW_STEP;
        addr     <= row_base + ROW_STEP;
      end else begin
        col  <= col + 9'd1;
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangular-window writer: streams pixels (valid/ready) or a fill colour
// into a window of the frame-buffer SRAM, then pulses done (or err when the
// window is rejected).
module fb_rect_writer
  import fb_pkg::*;
#(
  parameter int VBUF_W     = fb_pkg::VBUF_W,
  parameter int VBUF_H     = fb_pkg::VBUF_H,
  parameter int DATA_WIDTH = fb_pkg::FB_PIX_W,
  parameter int ADDR_WIDTH = fb_pkg::FB_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] fill_color,
  input  logic [8:0]            x0,
  input  logic [7:0]            y0,
  input  logic [8:0]            win_w,
  input  logic [7:0]            win_h,
  fb_rect_writer_if.master      bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [16:0]           pix_count
);

  fbw_state_t            state;
  fbw_win_t              win_in;
  logic                  mode_q;
  logic [DATA_WIDTH-1:0] color_q;
  logic                  win_ok;
  logic                  accept;
  logic                  wr;
  logic                  last;
  logic [ADDR_WIDTH-1:0] addr;

  assign win_in = '{x0: x0, y0: y0, w: win_w, h: win_h};
  assign win_ok = fbw_win_ok(win_in, VBUF_W, VBUF_H);
  assign accept = (state == FBW_IDLE) && start && win_ok;
  // Fill writes every ACTIVE cycle; stream writes only on a valid pixel.
  assign wr     = (state == FBW_ACTIVE) && (mode_q || bus.s_valid);

  // Bus outputs are combinational so the write lands on the handshake edge;
  // address/data are held at zero when no write is issued.
  assign bus.s_ready   = (state == FBW_ACTIVE) && !mode_q;
  assign bus.sram_en   = busy;
  assign bus.sram_we   = wr;
  assign bus.sram_addr = wr ? addr : '0;
  assign bus.sram_data = !wr ? '0 : (mode_q ? color_q : bus.s_data);

  fb_addr_gen #(
    .VBUF_W     (VBUF_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept),
    .step    (wr),
    .win     (win_in),
    .addr    (addr),
    .last    (last)
  );

  // Job FSM: accept/reject in IDLE, count writes in ACTIVE, one-cycle DONE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= FBW_IDLE;
      mode_q    <= 1'b0;
      color_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      pix_count <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        FBW_IDLE: begin
          if (start) begin
            if (win_ok) begin
              mode_q    <= mode;
              color_q   <= fill_color;
              pix_count <= '0;
              busy      <= 1'b1;
              state     <= FBW_ACTIVE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        FBW_ACTIVE: begin
          if (wr) begin
            pix_count <= pix_count + 17'd1;
            if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FBW_DONE;
            end
          end
        end
        FBW_DONE: state <= FBW_IDLE;
        default:  state <= FBW_IDLE;
      endcase
    end
  end

endmodule
